btn_debounce_arbiter: RTL and testbench

BTN_DEBOUNCE_ARBITER -- requirements
Module: btn_debounce_arbiter

---
 rtl/btn_debounce_arbiter.sv | 117 +++++++++++
 tb/tb_btn_debounce_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_arbiter.sv
// Debounces N push-button channels with a single shared 17-bit stability timer.
// Channels whose synchronized level differs from their debounced level are granted round-robin.
module btn_debounce_arbiter #(
  parameter int N    = 4,
  parameter int WAIT = 65536
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         d,
  output logic [N-1:0]         level,
  output logic [N-1:0]         tic,
  output logic                 busy,
  output logic [$clog2(N)-1:0] owner
);

  localparam int OW = $clog2(N);
  localparam logic [16:0] WAIT_M1 = 17'(WAIT - 1);

  typedef enum logic {IDLE, TIMING} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  sync1_q, sync2_q;
  logic [N-1:0]  level_q, level_d;
  logic [N-1:0]  tic_q, tic_d;
  logic [16:0]   cnt_q, cnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_q, last_d;
  logic          cool_q, cool_d;
  logic [N-1:0]  pend;
  logic [OW-1:0] grant;
  logic          found;
  int            idx;

  assign pend = sync2_q ^ level_q;

  // Round-robin search starting just after the most recent grant
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!found && pend[idx]) begin
        found = 1'b1;
        grant = OW'(idx);
      end
    end
  end

  // cool_q forces one dead IDLE cycle after every commit or abort
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    level_d = level_q;
    tic_d   = '0;
    cool_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!cool_q && (|pend)) begin
          owner_d = grant;
          last_d  = grant;
          state_d = TIMING;
        end
      end
      TIMING: begin
        if (sync2_q[owner_q] == level_q[owner_q]) begin
          cnt_d   = '0;
          cool_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == WAIT_M1) begin
          level_d[owner_q] = ~level_q[owner_q];
          tic_d[owner_q]   = ~level_q[owner_q];
          cnt_d            = '0;
          cool_d           = 1'b1;
          state_d          = IDLE;
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      last_q  <= OW'(N - 1);
      level_q <= '0;
      tic_q   <= '0;
      cool_q  <= 1'b0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      level_q <= level_d;
      tic_q   <= tic_d;
      cool_q  <= cool_d;
    end
  end

  // The grant cycle already counts as owning the timer
  assign busy  = (state_q == TIMING) || (!cool_q && (|pend));
  assign owner = ((state_q == TIMING) || !busy) ? owner_q : grant;
  assign level = level_q;
  assign tic   = tic_q;

endmodule

// File: tb/tb_btn_debounce_arbiter.sv
// Bench for btn_debounce_arbiter (N=4, WAIT=8): deadline-based reference model checked
// every cycle, plus directed scenarios with hand-computed latencies.
module tb_btn_debounce_arbiter;
  localparam int N    = 4;
  localparam int WAIT = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] d     = 4'b0000;
  logic [3:0] level, tic;
  logic       busy;
  logic [1:0] owner;

  btn_debounce_arbiter #(.N(N), .WAIT(WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .level(level), .tic(tic), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference model: channel state as plain arrays, timing held as an absolute deadline
  logic [3:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_tic = '0, m_pend;
  int         m_own = -1, m_last = N - 1, m_dl = 0, ec = 0, m_g;
  bit         m_cool = 1'b0, cmp_en = 1'b0;

  function automatic int rr(input logic [3:0] p, input int last);
    for (int k = 1; k <= N; k++)
      if (p[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_tic = '0;
      m_own = -1; m_last = N - 1; m_cool = 1'b0;
    end else begin
      ec++;
      m_pend = m_s2 ^ m_lvl;
      m_tic  = '0;
      if (m_own < 0) begin
        if (m_cool) m_cool = 1'b0;
        else if (m_pend != 0) begin
          m_g = rr(m_pend, m_last);
          m_own = m_g; m_last = m_g; m_dl = ec + WAIT;
        end
      end else if (m_s2[m_own] == m_lvl[m_own]) begin
        m_own = -1; m_cool = 1'b1;
      end else if (ec == m_dl) begin
        m_lvl[m_own] = ~m_lvl[m_own];
        m_tic[m_own] = m_lvl[m_own];
        m_own = -1; m_cool = 1'b1;
      end
      m_s2 = m_s1;
      m_s1 = d;
    end
  end

  initial forever begin : compare
    logic [3:0] p;
    bit         eb;
    int         eo;
    @(negedge clk);
    if (cmp_en) begin
      p  = m_s2 ^ m_lvl;
      eb = (m_own >= 0) || (!m_cool && p != 0);
      eo = (m_own >= 0) ? m_own : rr(p, m_last);
      chk("model_level", int'(level), int'(m_lvl));
      chk("model_tic", int'(tic), int'(m_tic));
      chk("model_busy", int'(busy), int'(eb));
      if (eb) chk("model_owner", int'(owner), eo);
    end
  end

  // Directed observation window; chg_k > 0 applies chg_v just before edge chg_k
  int lchg[4];
  int bcnt, tcnt, fown;

  task automatic observe(input int n, input int chg_k, input logic [3:0] chg_v);
    logic [3:0] l0;
    l0 = level;
    bcnt = 0; tcnt = 0; fown = -1;
    for (int i = 0; i < 4; i++) lchg[i] = 0;
    for (int k = 1; k <= n; k++) begin
      if (k == chg_k) d = chg_v;
      @(posedge clk); #1;
      if (busy) begin
        bcnt++;
        if (fown < 0) fown = int'(owner);
      end
      for (int i = 0; i < 4; i++) begin
        tcnt += int'(tic[i]);
        if (lchg[i] == 0 && level[i] != l0[i]) lchg[i] = k;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_tic"}, int'(tic), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_owner"}, int'(owner), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press on channel 1
    d = 4'b0010;
    observe(20, 0, 4'b0000);
    chk("press_latency", lchg[1], 11);
    chk("press_busy_cycles", bcnt, 9);
    chk("press_tic_count", tcnt, 1);
    chk("press_level", int'(level), 4'b0010);

    // Bounce on channel 2: high for 5 edges, then low again
    @(negedge clk);
    d = 4'b0110;
    observe(20, 6, 4'b0010);
    chk("bounce_busy_cycles", bcnt, 6);
    chk("bounce_tic_count", tcnt, 0);
    chk("bounce_level", int'(level), 4'b0010);

    // Simultaneous presses from a fresh reset
    d = 4'b0000;
    do_reset();
    d = 4'b1011;
    observe(40, 0, 4'b0000);
    chk("simul_commit0", lchg[0], 11);
    chk("simul_commit1", lchg[1], 21);
    chk("simul_commit3", lchg[3], 31);
    chk("simul_tic_count", tcnt, 3);
    chk("simul_level", int'(level), 4'b1011);

    // Release channel 0: falls after the timing period, no tic
    @(negedge clk);
    d = 4'b1010;
    observe(20, 0, 4'b0000);
    chk("release_latency", lchg[0], 11);
    chk("release_tic_count", tcnt, 0);

    @(negedge clk);
    d = 4'b0000;
    observe(40, 0, 4'b0000);

    // Reset while the shared counter sits at 4
    @(negedge clk);
    d = 4'b0010;
    observe(7, 0, 4'b0000);
    rst_n = 1'b0;
    #1 check_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    observe(20, 0, 4'b0000);
    chk("midreset_latency", lchg[1], 11);
    chk("midreset_tic_count", tcnt, 1);

    // Make channel 3 the last grant, then pend channels 0 and 3 together
    @(negedge clk);
    d = 4'b1010;
    observe(20, 0, 4'b0000);
    chk("ch3_latency", lchg[3], 11);
    @(negedge clk);
    d = 4'b0011;
    observe(30, 0, 4'b0000);
    chk("wrap_first_owner", fown, 0);
    chk("wrap_commit0", lchg[0], 11);
    chk("wrap_commit3", lchg[3], 21);
    chk("wrap_level", int'(level), 4'b0011);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
